// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam int unsigned MEM_WORDS_DEF  = 1024;
  localparam int unsigned WORD_IDX_W_DEF = $clog2(MEM_WORDS_DEF);

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid_c,
  output logic       pick_c
);

  always_comb begin
    valid_c = |req;
    pick_c  = PORT_CPU;
    if (req == 2'b11) begin
      pick_c = ~last;
    end else if (req[1]) begin
      pick_c = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the debug/DMA
// loader (port 1); one access outstanding, bad addresses rejected before the memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_err,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_err,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy_o
);

  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned WORD_W = ADDR_W - 2;

  state_e state, state_nxt;
  logic   last, last_nxt;
  logic   owner, owner_nxt;

  logic              arb_valid;
  logic              arb_pick;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [WORD_W-1:0] win_word;
  logic              addr_bad;

  logic [1:0] gnt_c;
  logic [1:0] err_c;
  logic [1:0] rvalid_c;

  rr_arb2 u_arb (
    .req     ({p1_req, p0_req}),
    .last    (last),
    .valid_c (arb_valid),
    .pick_c  (arb_pick)
  );

  // Winner's request fields and the address check applied to them.
  always_comb begin
    win_we    = arb_pick ? p1_we    : p0_we;
    win_addr  = arb_pick ? p1_addr  : p0_addr;
    win_wdata = arb_pick ? p1_wdata : p0_wdata;
    win_word  = win_addr[ADDR_W-1:2];
    addr_bad  = (win_addr[1:0] != 2'b00) || (win_word >= WORD_W'(MEM_WORDS));
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      last  <= PORT_DBG;
      owner <= PORT_CPU;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      owner <= owner_nxt;
    end
  end

  // Next state and the combinational grant/memory controls; everything is
  // forced quiet while Reset is low so a pending read never reports back.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = owner;
    gnt_c     = 2'b00;
    err_c     = 2'b00;
    rvalid_c  = 2'b00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = '0;
    if (Reset) begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt_c[arb_pick] = 1'b1;
            last_nxt        = arb_pick;
            if (addr_bad) begin
              err_c[arb_pick] = 1'b1;
            end else if (win_we) begin
              mem_we    = 1'b1;
              mem_addr  = 32'(win_word[IDX_W-1:0]);
              mem_wdata = win_wdata;
            end else begin
              mem_re    = 1'b1;
              mem_addr  = 32'(win_word[IDX_W-1:0]);
              owner_nxt = arb_pick;
              state_nxt = RESP;
            end
          end
        end
        RESP: begin
          rvalid_c[owner] = 1'b1;
          state_nxt       = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    p0_gnt    = gnt_c[0];
    p1_gnt    = gnt_c[1];
    p0_err    = err_c[0];
    p1_err    = err_c[1];
    p0_rvalid = rvalid_c[0];
    p1_rvalid = rvalid_c[1];
    p0_rdata  = rvalid_c[0] ? mem_rdata : '0;
    p1_rdata  = rvalid_c[1] ? mem_rdata : '0;
  end

  assign busy_o = (state == RESP);

endmodule
